// File: rtl/nco_phase_rotator.sv
// NCO for the phase-corrector loop: accumulates FCW + PI correction and maps the
// phase through a quarter-wave sine ROM into a registered cos/sin pair, 3-cycle latency.
module nco_phase_rotator #(
    parameter int                  NB_DATA     = 16,
    parameter int                  NB_PHASE    = 24,
    parameter int                  NB_LUT_ADDR = 8,
    parameter int                  NB_OUT      = 16,
    parameter logic [NB_PHASE-1:0] FCW_NOMINAL = '0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic                i_clear,
    input  logic [NB_DATA-1:0]  i_data,
    output logic [NB_PHASE-1:0] o_phase,
    output logic [NB_OUT-1:0]   o_cos,
    output logic [NB_OUT-1:0]   o_sin,
    output logic                o_valid
);

    localparam int    DEPTH       = 2 ** NB_LUT_ADDR;
    localparam int    NB_MAG      = NB_OUT - 1;
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    typedef logic [DEPTH-1:0][NB_MAG-1:0] lut_t;

    // Integer Taylor series in Q30 so the ROM is rebuilt from the parameters alone.
    function automatic lut_t gen_lut();
        lut_t   t;
        longint x;
        longint term;
        longint sum;
        longint amp;
        longint v;
        t   = '0;
        amp = (longint'(1) <<< NB_MAG) - 1;
        for (int j = 0; j < DEPTH; j++) begin
            x    = (HALF_PI_Q30 * longint'(2 * j + 1)) / longint'(2 * DEPTH);
            term = x;
            sum  = x;
            for (int n = 1; n < 12; n++) begin
                term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
                sum  = sum + term;
            end
            v    = ((sum * amp) + (longint'(1) <<< 29)) >>> 30;
            t[j] = v[NB_MAG-1:0];
        end
        return t;
    endfunction

    localparam lut_t LUT = gen_lut();

    logic [NB_PHASE-1:0]    acc_q, acc_d;
    logic                   s0_valid_q;

    logic [NB_LUT_ADDR-1:0] sin_addr_q, cos_addr_q;
    logic                   sin_neg1_q, cos_neg1_q;
    logic [NB_PHASE-1:0]    phase1_q;
    logic                   s1_valid_q;

    logic [NB_MAG-1:0]      sin_mag_q, cos_mag_q;
    logic                   sin_neg2_q, cos_neg2_q;
    logic [NB_PHASE-1:0]    phase2_q;
    logic                   s2_valid_q;

    logic [NB_PHASE-1:0]    phase_q;
    logic [NB_OUT-1:0]      sin_q, cos_q;
    logic                   valid_q;

    logic [NB_PHASE-1:0]    inc;
    logic [1:0]             quad_sin, quad_cos;
    logic [NB_LUT_ADDR-1:0] lut_addr;
    logic [NB_LUT_ADDR-1:0] sin_addr_d, cos_addr_d;
    logic [NB_OUT-1:0]      sin_mag_ext, cos_mag_ext;
    logic [NB_OUT-1:0]      sin_val, cos_val;

    assign inc = FCW_NOMINAL + {{(NB_PHASE - NB_DATA){i_data[NB_DATA-1]}}, i_data};

    always_comb begin
        acc_d = acc_q;
        if (i_clear) begin
            acc_d = '0;
        end else if (i_valid) begin
            acc_d = acc_q + inc;
        end
    end

    // cos(x) = sin(x + quarter turn): the cos path just uses the next quadrant.
    assign quad_sin   = acc_q[NB_PHASE-1 -: 2];
    assign quad_cos   = quad_sin + 2'd1;
    assign lut_addr   = acc_q[NB_PHASE-3 -: NB_LUT_ADDR];
    assign sin_addr_d = quad_sin[0] ? ~lut_addr : lut_addr;
    assign cos_addr_d = quad_cos[0] ? ~lut_addr : lut_addr;

    assign sin_mag_ext = {1'b0, sin_mag_q};
    assign cos_mag_ext = {1'b0, cos_mag_q};
    assign sin_val     = sin_neg2_q ? (~sin_mag_ext + 1'b1) : sin_mag_ext;
    assign cos_val     = cos_neg2_q ? (~cos_mag_ext + 1'b1) : cos_mag_ext;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q      <= '0;
            s0_valid_q <= 1'b0;
            sin_addr_q <= '0;
            cos_addr_q <= '0;
            sin_neg1_q <= 1'b0;
            cos_neg1_q <= 1'b0;
            phase1_q   <= '0;
            s1_valid_q <= 1'b0;
            sin_mag_q  <= '0;
            cos_mag_q  <= '0;
            sin_neg2_q <= 1'b0;
            cos_neg2_q <= 1'b0;
            phase2_q   <= '0;
            s2_valid_q <= 1'b0;
            phase_q    <= '0;
            sin_q      <= '0;
            cos_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            s0_valid_q <= i_valid;

            sin_addr_q <= sin_addr_d;
            cos_addr_q <= cos_addr_d;
            sin_neg1_q <= quad_sin[1];
            cos_neg1_q <= quad_cos[1];
            phase1_q   <= acc_q;
            s1_valid_q <= s0_valid_q;

            sin_mag_q  <= LUT[sin_addr_q];
            cos_mag_q  <= LUT[cos_addr_q];
            sin_neg2_q <= sin_neg1_q;
            cos_neg2_q <= cos_neg1_q;
            phase2_q   <= phase1_q;
            s2_valid_q <= s1_valid_q;

            // Outputs only move on valid samples so bubbles leave the last value visible.
            valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                phase_q <= phase2_q;
                sin_q   <= sin_val;
                cos_q   <= cos_val;
            end
        end
    end

    assign o_phase = phase_q;
    assign o_sin   = sin_q;
    assign o_cos   = cos_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_nco_phase_rotator.sv
// Directed bench for nco_phase_rotator: four instances with different nominal FCW
// share one stimulus stream; each vector checks the instance it targets.
module tb_nco_phase_rotator;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic        i_clear;
    logic [15:0] i_data;

    logic [23:0]        ph [4];
    logic signed [15:0] sn [4];
    logic signed [15:0] cs [4];
    logic               vl [4];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          sel;
        bit          first;
        bit          v;
        bit          c;
        logic [15:0] d;
        bit          ev;
        bit          chk;
        int          ep;
        int          es;
        int          ec;
    } vec_t;

    vec_t vecs[$];

    logic [15:0] seg3_d [11] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFF00, 16'hFF00,
                                 16'hFE00, 16'hFD00, 16'hFD00, 16'hFD00, 16'hFD00};
    int          seg3_p [11] = '{'h200, 'h400, 'h600, 'h800, 'h800, 'h800,
                                 'h700, 'h500, 'h300, 'h100, 'hFFFF00};
    bit          seg4_v [8]  = '{1, 0, 1, 1, 0, 0, 0, 0};
    int          seg4_p [8]  = '{0, 0, 0, 'h100, 'h100, 'h200, 'h300, 'h300};
    bit          seg4_e [8]  = '{0, 0, 0, 1, 0, 1, 1, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nco_phase_rotator #(.FCW_NOMINAL(24'h000000)) u_dut0 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_clear(i_clear), .i_data(i_data),
        .o_phase(ph[0]), .o_cos(cs[0]), .o_sin(sn[0]), .o_valid(vl[0]));
    nco_phase_rotator #(.FCW_NOMINAL(24'h400000)) u_dut1 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_clear(i_clear), .i_data(i_data),
        .o_phase(ph[1]), .o_cos(cs[1]), .o_sin(sn[1]), .o_valid(vl[1]));
    nco_phase_rotator #(.FCW_NOMINAL(24'h000100)) u_dut2 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_clear(i_clear), .i_data(i_data),
        .o_phase(ph[2]), .o_cos(cs[2]), .o_sin(sn[2]), .o_valid(vl[2]));
    nco_phase_rotator #(.FCW_NOMINAL(24'h200000)) u_dut3 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_clear(i_clear), .i_data(i_data),
        .o_phase(ph[3]), .o_cos(cs[3]), .o_sin(sn[3]), .o_valid(vl[3]));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic add(input int sel, input bit first, input bit v, input bit c,
                       input logic [15:0] d, input bit ev, input bit chk,
                       input int ep, input int es, input int ec);
        vecs.push_back('{sel, first, v, c, d, ev, chk, ep, es, ec});
    endtask

    task automatic step(input bit v, input bit c, input logic [15:0] d);
        i_valid = v;
        i_clear = c;
        i_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_data  = '0;
        i_rst   = 1'b1;
        @(posedge clk);
        #1;
        i_rst   = 1'b0;
    endtask

    task automatic check_out(input string tag, input int s, input bit ev,
                             input int ep, input int es, input int ec);
        check({tag, " valid"}, int'(vl[s]), int'(ev));
        check({tag, " phase"}, int'(ph[s]), ep);
        check({tag, " sin"},   int'(sn[s]), es);
        check({tag, " cos"},   int'(cs[s]), ec);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_data  = '0;
        #2;
        for (int s = 0; s < 4; s++) check_out($sformatf("reset dut%0d", s), s, 0, 0, 0, 0);

        // Segment 1: clear+valid on FCW=0 emits phase 0 three cycles later.
        add(0, 1, 1, 1, 16'h0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 16'h0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 16'h0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 16'h0, 1, 1, 0, 101, 32767);
        add(0, 0, 0, 0, 16'h0, 0, 1, 0, 101, 32767);

        // Segment 2: quarter-turn steps, silent wrap.
        add(1, 1, 1, 0, 16'h0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 16'h0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 16'h0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 16'h0, 1, 1, 'h400000, 32767, -101);
        add(1, 0, 1, 0, 16'h0, 1, 1, 'h800000, -101, -32767);
        add(1, 0, 0, 0, 16'h0, 1, 1, 'hC00000, -32767, 101);
        add(1, 0, 0, 0, 16'h0, 1, 1, 'h000000, 101, 32767);
        add(1, 0, 0, 0, 16'h0, 1, 1, 'h400000, 32767, -101);
        add(1, 0, 0, 0, 16'h0, 0, 1, 'h400000, 32767, -101);

        // Segment 3: signed correction, hold, retreat and wrap below zero.
        for (int i = 0; i < 14; i++) begin
            if (i < 3)
                add(2, i == 0, 1, 0, seg3_d[i], 0, 1, 0, 0, 0);
            else
                add(2, 0, i < 11, 0, (i < 11) ? seg3_d[i] : 16'h0, 1, 1, seg3_p[i-3],
                    (i == 13) ? -101 : 101, 32767);
        end

        // Segment 4: valid pattern 1,0,1,1,0 reappears three cycles later.
        for (int i = 0; i < 8; i++)
            add(2, i == 0, seg4_v[i], 0, 16'h0, seg4_e[i], 1, seg4_p[i],
                (i < 3) ? 0 : 101, (i < 3) ? 0 : 32767);

        // Segment 5: eighth-turn phase exercises a mid-table address and its mirror.
        add(3, 1, 1, 0, 16'h0, 0, 1, 0, 0, 0);
        add(3, 0, 1, 0, 16'h0, 0, 1, 0, 0, 0);
        add(3, 0, 0, 0, 16'h0, 0, 1, 0, 0, 0);
        add(3, 0, 0, 0, 16'h0, 1, 1, 'h200000, 23241, 23099);
        add(3, 0, 0, 0, 16'h0, 1, 1, 'h400000, 32767, -101);

        foreach (vecs[i]) begin
            if (vecs[i].first) do_reset();
            step(vecs[i].v, vecs[i].c, vecs[i].d);
            check($sformatf("vec%0d valid", i), int'(vl[vecs[i].sel]), int'(vecs[i].ev));
            if (vecs[i].chk) begin
                check($sformatf("vec%0d phase", i), int'(ph[vecs[i].sel]), vecs[i].ep);
                check($sformatf("vec%0d sin", i),   int'(sn[vecs[i].sel]), vecs[i].es);
                check($sformatf("vec%0d cos", i),   int'(cs[vecs[i].sel]), vecs[i].ec);
            end
        end

        // Asynchronous reset with samples in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 16'h0);
        check_out("pre-reset", 2, 1, 'h100, 101, 32767);
        #2;
        i_rst = 1'b1;
        #1;
        check_out("async reset", 2, 0, 0, 0, 0);
        #1;
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 16'h0);
            check($sformatf("post-reset stale %0d", i), int'(vl[2]), 0);
        end
        step(1, 0, 16'h0);
        step(0, 0, 16'h0);
        step(0, 0, 16'h0);
        check("post-reset gap", int'(vl[2]), 0);
        step(0, 0, 16'h0);
        check_out("post-reset first", 2, 1, 'h100, 101, 32767);

        // Clear without valid at acc=0x123456; in-flight samples still emerge.
        do_reset();
        for (int i = 0; i < 37; i++) step(1, 0, (i < 36) ? 16'h7FFF : 16'h347A);
        step(0, 1, 16'h0);
        step(0, 0, 16'h0);
        check("inflight s35 valid", int'(vl[0]), 1);
        check("inflight s35 phase", int'(ph[0]), 'h11FFDC);
        step(0, 0, 16'h0);
        check("inflight s36 valid", int'(vl[0]), 1);
        check("inflight s36 phase", int'(ph[0]), 'h123456);
        step(0, 0, 16'h0);
        check("clear bubble valid", int'(vl[0]), 0);
        check("clear bubble hold",  int'(ph[0]), 'h123456);
        step(1, 0, 16'h0010);
        check("after clear gap0", int'(vl[0]), 0);
        step(0, 0, 16'h0);
        check("after clear gap1", int'(vl[0]), 0);
        step(0, 0, 16'h0);
        check("after clear gap2", int'(vl[0]), 0);
        step(0, 0, 16'h0);
        check_out("after clear", 0, 1, 'h10, 101, 32767);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
